dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, memory size in 32-bit words; legal values are powers of two from 4 to 65536.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0; it is DEPTH*4 aligned.
REQ-003 SHALL have parameter LATENCY, default 1, cycles from request acceptance to io_respValid; legal range is 1 to 15.
REQ-004 SHALL have port clock, input, 1, the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port io_reqValid, input, 1, request present; the initiator holds it high until it sees io_respValid.
REQ-007 SHALL have port io_addr, input, 32, byte address.
REQ-008 SHALL have port io_wen, input, 1, 1 means write and 0 means read.
REQ-009 SHALL have port io_wdata, input, 32, write data, already placed on its byte lanes.
REQ-010 SHALL have port io_wmask, input, 4, byte-lane write enables.
REQ-011 SHALL have port io_size, input, 2, access size; it is accepted but not used.
REQ-012 SHALL have port io_respValid, output, 1, one-cycle response pulse.
REQ-013 SHALL have port io_rdata, output, 32, read data; it is valid only while io_respValid is 1.

Function
REQ-014 SHALL implement the states IDLE, WAIT and RESP.
REQ-015 SHALL accept a request in IDLE when io_reqValid=1, latching io_addr, io_wen, io_wdata and io_wmask on that edge; later changes to these inputs SHALL be ignored until the next acceptance.
REQ-016 On acceptance SHALL go to RESP when LATENCY=1, and otherwise go to WAIT with the down-counter loaded with LATENCY-2.
REQ-017 In WAIT SHALL decrement the counter each cycle and go to RESP on the cycle after it reads 0.
REQ-018 SHALL drive io_respValid=1 only in RESP, for exactly one cycle, then return to IDLE.
REQ-019 Request accepted at edge T SHALL produce io_respValid high in cycle T+LATENCY.
REQ-020 On a read SHALL drive io_rdata with the full aligned word mem[(addr-BASE_ADDR)>>2], ignoring addr[1:0] and io_size.
REQ-021 On a write SHALL update only the bytes whose io_wmask bit is 1, on the edge that ends the RESP cycle, and SHALL drive io_rdata=0.
REQ-022 io_rdata SHALL be 32'h0 whenever io_respValid=0.
REQ-023 An address outside BASE_ADDR to BASE_ADDR+4*DEPTH-1 SHALL still produce a response after the normal latency; a read SHALL return 32'h0 and a write SHALL leave memory unchanged.
REQ-024 io_reqValid still high in the cycle after RESP SHALL be treated as a new request and accepted in IDLE.
REQ-025 io_reqValid dropping in WAIT SHALL not abort the access; the response SHALL still be issued.
REQ-026 A write with io_wmask=4'b0000 SHALL respond normally and leave memory unchanged.
REQ-027 A read followed immediately by a write to the same word SHALL return the pre-write data.

Reset
REQ-028 While reset_n=0, SHALL hold the state at IDLE, the counter at 0, io_respValid at 0 and io_rdata at 0.
REQ-029 Memory array contents SHALL not be reset.
REQ-030 Reset asserted mid-access (WAIT or RESP) SHALL abort the access and SHALL perform no memory write.
REQ-031 A request present at reset release SHALL be accepted on the first rising edge with reset_n=1.

Configuration
REQ-032 With macro DMEM_RAND_STALL_EN defined, an 8-bit Fibonacci LFSR SHALL be implemented, with taps 8,6,5,4, reset seed 8'hA5, advancing every cycle.
REQ-033 With DMEM_RAND_STALL_EN defined, SHALL add extra WAIT cycles equal to LFSR[1:0], sampled at acceptance, so the latency becomes LATENCY to LATENCY+3; LATENCY=1 with a nonzero sample SHALL route through WAIT.
REQ-034 Without DMEM_RAND_STALL_EN, SHALL have no LFSR and a fixed latency of exactly LATENCY.

Verification
REQ-035 Reset, then LATENCY=1, write addr 0x8000_0010, wdata 0x1122_3344, mask 4'b1111, then read the same address -> io_respValid one cycle after each acceptance; read returns 0x1122_3344.
REQ-036 After REQ-035, write 0x0000_AB00 to addr 0x8000_0011 with mask 4'b0010, then read 0x8000_0010 -> read returns 0x1122_AB44.
REQ-037 LATENCY=4, read with io_reqValid dropped in the second WAIT cycle -> io_respValid still in cycle T+4; no second response.
REQ-038 io_reqValid held high continuously for three reads -> three io_respValid pulses at T+1, T+3, T+5, each with the correct word.
REQ-039 Read of 0x0000_0000 (out of range) -> response at normal latency with io_rdata=0; write there -> memory unchanged.
REQ-040 Write accepted, reset_n pulsed low in WAIT, then the same word is read -> old data returned; io_respValid low throughout reset.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port word memory answering one request at a time after LATENCY cycles.
// Optional `DMEM_RAND_STALL_EN adds 0-3 pseudo-random stall cycles drawn from an 8-bit LFSR.
module dmem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LATENCY   = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        io_reqValid,
  input  logic [31:0] io_addr,
  input  logic        io_wen,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wmask,
  input  logic [1:0]  io_size,
  output logic        io_respValid,
  output logic [31:0] io_rdata
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [4:0]  count;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wen_q;
  logic [3:0]  wmask_q;
  logic [31:0] mem [DEPTH];

  logic [4:0]  wait_cycles;
  logic [31:0] sel_addr;
  logic        sel_wen;
  logic        sel_hit;
  logic        q_hit;
  logic [31:0] read_word;
  logic        unused_bits;

`ifdef DMEM_RAND_STALL_EN
  logic [7:0] lfsr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign wait_cycles = 5'(LATENCY - 1) + {3'b000, lfsr[1:0]};
`else
  assign wait_cycles = 5'(LATENCY - 1);
`endif

  // With LATENCY=1 the word is fetched on the accepting edge, so the lookup uses the live inputs in IDLE.
  assign sel_addr    = (state == IDLE) ? io_addr : addr_q;
  assign sel_wen     = (state == IDLE) ? io_wen  : wen_q;
  assign sel_hit     = (sel_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign q_hit       = (addr_q[31:AW+2]   == BASE_ADDR[31:AW+2]);
  assign read_word   = (!sel_wen && sel_hit) ? mem[sel_addr[AW+1:2]] : 32'h0;
  assign unused_bits = ^{io_size, sel_addr[1:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      count        <= 5'd0;
      io_respValid <= 1'b0;
      io_rdata     <= 32'h0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      wen_q        <= 1'b0;
      wmask_q      <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (io_reqValid) begin
            addr_q  <= io_addr;
            wen_q   <= io_wen;
            wdata_q <= io_wdata;
            wmask_q <= io_wmask;
            if (wait_cycles == 5'd0) begin
              state        <= RESP;
              io_respValid <= 1'b1;
              io_rdata     <= read_word;
            end else begin
              state <= WAIT;
              count <= wait_cycles - 5'd1;
            end
          end
        end
        WAIT: begin
          if (count == 5'd0) begin
            state        <= RESP;
            io_respValid <= 1'b1;
            io_rdata     <= read_word;
          end else begin
            count <= count - 5'd1;
          end
        end
        RESP: begin
          state        <= IDLE;
          io_respValid <= 1'b0;
          io_rdata     <= 32'h0;
        end
        default: begin
          state        <= IDLE;
          io_respValid <= 1'b0;
          io_rdata     <= 32'h0;
        end
      endcase
    end
  end

  // The write lands on the edge that closes RESP, so a reset that aborted the access never reaches here.
  always_ff @(posedge clock) begin
    if (state == RESP && wen_q && q_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_q[b]) begin
          mem[addr_q[AW+1:2]][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance 0 runs LATENCY=1, instance 1 runs LATENCY=4.
module tb_dmem_responder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid  [2];
  logic [31:0] req_addr   [2];
  logic        req_wen    [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_wmask  [2];
  logic [1:0]  req_size   [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int last_resp_cyc [2];
  exp_t sb_q0 [$];
  exp_t sb_q1 [$];
  logic [31:0] model [2][DEPTH];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .io_reqValid(req_valid[0]), .io_addr(req_addr[0]), .io_wen(req_wen[0]),
    .io_wdata(req_wdata[0]), .io_wmask(req_wmask[0]), .io_size(req_size[0]),
    .io_respValid(resp_valid[0]), .io_rdata(resp_rdata[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(4)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .io_reqValid(req_valid[1]), .io_addr(req_addr[1]), .io_wen(req_wen[1]),
    .io_wdata(req_wdata[1]), .io_wmask(req_wmask[1]), .io_size(req_size[1]),
    .io_respValid(resp_valid[1]), .io_rdata(resp_rdata[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pendingCount(input int w);
    return (w == 0) ? sb_q0.size() : sb_q1.size();
  endfunction

  function automatic exp_t popExp(input int w);
    if (w == 0) return sb_q0.pop_front();
    return sb_q1.pop_front();
  endfunction

  // Pops one expectation per response pulse; checks quiet outputs otherwise.
  always @(negedge clock) begin : monitor
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        checkOutput($sformatf("reset_resp%0d", i), {31'b0, resp_valid[i]}, 32'h0);
        checkOutput($sformatf("reset_rdata%0d", i), resp_rdata[i], 32'h0);
      end else if (resp_valid[i]) begin
        if (pendingCount(i) == 0) begin
          checkOutput($sformatf("spurious_resp%0d", i), {31'b0, resp_valid[i]}, 32'h0);
        end else begin
          e = popExp(i);
          checkOutput($sformatf("rdata%0d", i), resp_rdata[i], e.data);
          checkOutput($sformatf("latency%0d", i), 32'(cyc), 32'(e.due));
        end
      end else begin
        checkOutput($sformatf("idle_rdata%0d", i), resp_rdata[i], 32'h0);
      end
    end
  end

  // Called on a falling edge; returns on the falling edge where the response is seen.
  task automatic applyStimulus(input int w, input logic [31:0] addr, input logic wen,
                               input logic [31:0] wdata, input logic [3:0] wmask,
                               input bit hold, input bit drop_early);
    int          accept;
    int          lat;
    int          idx;
    bit          hit;
    bit          seen;
    logic [31:0] offs;
    exp_t        e;
    lat    = (w == 0) ? 1 : 4;
    accept = (last_resp_cyc[w] == cyc) ? cyc + 2 : cyc + 1;
    offs   = addr - BASE;
    hit    = (offs < 32'(DEPTH * 4));
    idx    = int'(offs[5:2]);
    e.due  = accept + lat - 1;
    e.data = (!wen && hit) ? model[w][idx] : 32'h0;
    if (wen && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) model[w][idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    if (w == 0) sb_q0.push_back(e);
    else        sb_q1.push_back(e);
    req_valid[w] = 1'b1;
    req_addr[w]  = addr;
    req_wen[w]   = wen;
    req_wdata[w] = wdata;
    req_wmask[w] = wmask;
    req_size[w]  = 2'($urandom_range(3));
    while (cyc < accept) @(negedge clock);
    req_addr[w]  = ~addr;
    req_wdata[w] = ~wdata;
    req_wmask[w] = ~wmask;
    req_wen[w]   = ~wen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (drop_early && cyc == accept + 1) req_valid[w] = 1'b0;
      if (resp_valid[w]) seen = 1'b1;
      else @(negedge clock);
    end
    if (!seen) checkOutput($sformatf("resp_timeout%0d", w), {31'b0, resp_valid[w]}, 32'h1);
    last_resp_cyc[w] = cyc;
    if (!hold) req_valid[w] = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_addr[i]  = 32'h0;
      req_wen[i]   = 1'b0;
      req_wdata[i] = 32'h0;
      req_wmask[i] = 4'h0;
      req_size[i]  = 2'b00;
      last_resp_cyc[i] = -10;
    end
    idleCycles(3);
    reset_n = 1'b1;
    idleCycles(2);

    // Full write, then read back; then a single-lane write on an unaligned address.
    applyStimulus(0, BASE + 32'h10, 1'b1, 32'h1122_3344, 4'b1111, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(0, BASE + 32'h10, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(0, BASE + 32'h11, 1'b1, 32'h0000_AB00, 4'b0010, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(0, BASE + 32'h10, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    idleCycles(1);

    // Three back-to-back reads with the request held high throughout.
    applyStimulus(0, BASE + 32'h14, 1'b1, 32'hA5A5_0014, 4'b1111, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(0, BASE + 32'h18, 1'b1, 32'h5A5A_0018, 4'b1111, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(0, BASE + 32'h10, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    applyStimulus(0, BASE + 32'h14, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    applyStimulus(0, BASE + 32'h18, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    idleCycles(2);

    // Out-of-range accesses, and a zero-mask write.
    applyStimulus(0, 32'h0000_0000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(0, 32'h0000_0010, 1'b1, 32'hFFFF_FFFF, 4'b1111, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(0, BASE + 32'h10, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(0, BASE + 32'h14, 1'b1, 32'h0000_0000, 4'b0000, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(0, BASE + 32'h14, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    idleCycles(1);

    // Read then immediate write to the same word, then confirm the new value.
    applyStimulus(0, BASE + 32'h14, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    applyStimulus(0, BASE + 32'h14, 1'b1, 32'h0BAD_F00D, 4'b1111, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(0, BASE + 32'h14, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    idleCycles(1);

    // First and last word of the window, and the first address past it.
    applyStimulus(0, BASE, 1'b1, 32'h0000_0001, 4'b1111, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(0, BASE + 32'h3C, 1'b1, 32'h3C3C_3C3C, 4'b1111, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(0, BASE + 32'h40, 1'b1, 32'h4040_4040, 4'b1111, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(0, BASE + 32'h3C, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(0, BASE + 32'h40, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(0, BASE, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    idleCycles(2);

    // LATENCY=4: request dropped during WAIT still gets exactly one response.
    applyStimulus(1, BASE + 32'h20, 1'b1, 32'h2020_2020, 4'b1111, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(1, BASE + 32'h20, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    idleCycles(4);

    // Reset pulse in WAIT aborts the write; request present at release is accepted at once.
    req_valid[1] = 1'b1;
    req_addr[1]  = BASE + 32'h20;
    req_wen[1]   = 1'b1;
    req_wdata[1] = 32'hDEAD_BEEF;
    req_wmask[1] = 4'b1111;
    @(negedge clock);
    req_valid[1] = 1'b0;
    reset_n      = 1'b0;
    idleCycles(3);
    reset_n = 1'b1;
    applyStimulus(1, BASE + 32'h23, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    idleCycles(6);

    checkOutput("pending0", 32'(sb_q0.size()), 32'h0);
    checkOutput("pending1", 32'(sb_q1.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
